enemy_slot_scheduler: RTL
=========================

Name: enemy_slot_scheduler

Overview:
Owns the 10 enemy slots that feed enemy_pixel_gen and drives its packed enemy_x, enemy_y, enemy_vi and enemy_type buses. It accepts spawn requests from the wave logic over a valid/ready handshake and applies kill requests from collision logic. Once per frame it walks every slot and advances each enemy vertically, retiring enemies that leave the playfield. It runs in the clk_25MHz domain, between game control and the pixel pipeline.

Parameters:
N_SLOTS, 10, number of enemy slots (bus widths below assume 10)
Y_LIMIT, 480, y value at or beyond which an enemy retires
SPD_T0, 1, pixels per frame for type 0
SPD_T1, 2, pixels per frame for type 1
SPD_T2, 1, pixels per frame for type 2

Ports:
clk_25MHz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
spawn_valid  in  1  spawn request
spawn_ready  out  1  scheduler can accept a spawn this cycle
spawn_type  in  3  enemy type 0..2
spawn_x  in  9  playfield x, 0..319
hit_valid  in  1  kill request
hit_idx  in  4  slot to kill
enemy_x  out  90  slot i at bits [9i+8:9i]
enemy_y  out  90  slot i at bits [9i+8:9i]
enemy_vi  out  10  slot i alive
enemy_type  out  30  slot i at bits [3i+2:3i]
active_count  out  4  number of alive slots
busy  out  1  frame update in progress
overrun  out  1  one-cycle pulse: frame_tick arrived while busy
spawn_err  out  1  one-cycle pulse: spawn accepted with type > 2

Behaviour:
- Reset (async assert, sync release): all slot x, y, type and vi = 0; active_count = 0; busy = 0; overrun = 0; spawn_err = 0; state = IDLE.
- All outputs are registered. Slot state changes appear on the buses the cycle after the triggering edge.
- FSM states:
  - IDLE: on frame_tick, go to UPDATE with slot pointer = 0.
  - UPDATE: process one slot per cycle, pointer 0..9. After slot 9, return to IDLE. A full update takes exactly 10 cycles.
  - busy = 1 in UPDATE.
- Update of slot p, only when vi[p] = 1:
  - ny = y + speed(type), computed at 10 bits.
  - If ny >= Y_LIMIT: vi[p] = 0, y unchanged.
  - Otherwise y = ny[8:0].
  - x is never modified.
- Spawn handshake:
  - spawn_ready = (state == IDLE) && (at least one slot has vi = 0) && !frame_tick.
  - Transfer occurs when spawn_valid && spawn_ready.
  - On transfer, the lowest-index free slot gets x = spawn_x, y = 0, type = spawn_type, vi = 1.
  - If spawn_type > 2: the transfer is consumed, no slot is written, and spawn_err pulses.
  - The requester holds spawn_valid and data stable until ready.
- Kill:
  - hit_valid with hit_idx < 10 clears vi[hit_idx] in any state.
  - hit_idx >= 10 is ignored.
  - x, y and type are retained.
- Simultaneous events:
  - Kill and update on the same slot in the same cycle: kill wins, vi = 0.
  - Kill and spawn in the same cycle: the free-slot search uses pre-kill vi, so the killed slot is not reused that cycle.
  - frame_tick while busy: ignored; overrun pulses; the update in progress continues.
- active_count is the registered popcount of the next vi value, consistent with enemy_vi on the same cycle.
- Coordinates are 9-bit unsigned. The pixel generator adds the 160 horizontal offset; this block does not.

Decomposition:
- Package enemy_pkg holds:
  - N_SLOTS, COORD_W = 9, TYPE_W = 3
  - Type codes ENEMY_T0/T1/T2
  - Speed constants and Y_LIMIT
  - FSM state encoding
- Sub-module enemy_free_slot_finder:
  - Combinational priority encoder over ~vi.
  - Outputs free_idx[3:0] and any_free.

Test Plan:
- Reset then spawn(type 1, x = 100): slot 0 gets x = 100, y = 0, vi = 1, type = 1 the next cycle; active_count = 1.
- Fill all 10 slots: spawn_ready drops after the 10th transfer. Kill slot 4: ready rises, and the next spawn lands in slot 4.
- Slot 0 type 1 at y = 10, pulse frame_tick:
  - busy stays high exactly 10 cycles.
  - y = 12 after the update.
  - Type 0 slot at y = 479 retires (vi = 0), y stays 479.
- Assert hit_idx = 3 on the exact cycle slot 3 is updated: vi[3] = 0. hit_idx = 12 changes nothing.
- frame_tick during UPDATE: overrun pulses once and the update completes on schedule. Spawn_valid held during UPDATE is accepted on the first IDLE cycle.
- spawn_type = 5: one-cycle spawn_err, no slot changes. Assert rst_n low mid-UPDATE: all buses are zero immediately.

Source files
------------

// File: rtl/enemy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enemy_pkg
// Purpose  : Shared constants, type codes, FSM encoding and the per-type speed
//            lookup for the enemy slot scheduler.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package enemy_pkg;

    localparam int N_SLOTS = 10;
    localparam int COORD_W = 9;
    localparam int TYPE_W  = 3;
    localparam int IDX_W   = 4;

    // Retirement threshold on the vertical coordinate
    localparam int Y_LIMIT = 480;

    // Vertical speed in pixels per frame, per enemy type
    localparam int SPD_T0  = 1;
    localparam int SPD_T1  = 2;
    localparam int SPD_T2  = 1;

    localparam logic [TYPE_W-1:0] ENEMY_T0 = 3'd0;
    localparam logic [TYPE_W-1:0] ENEMY_T1 = 3'd1;
    localparam logic [TYPE_W-1:0] ENEMY_T2 = 3'd2;

    localparam logic [IDX_W-1:0] SLOT_LIMIT = IDX_W'(N_SLOTS);
    localparam logic [IDX_W-1:0] LAST_SLOT  = IDX_W'(N_SLOTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_e;

    // Speed widened to COORD_W+1 bits so y + speed cannot wrap before the
    // Y_LIMIT comparison.
    function automatic logic [COORD_W:0] enemy_speed(input logic [TYPE_W-1:0] t);
        case (t)
            ENEMY_T1: return (COORD_W+1)'(SPD_T1);
            ENEMY_T2: return (COORD_W+1)'(SPD_T2);
            default:  return (COORD_W+1)'(SPD_T0);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_free_slot_finder.sv
`default_nettype none
// ============================================================================
// Module   : enemy_free_slot_finder
// Purpose  : Combinational priority encoder returning the lowest-index slot
//            whose alive flag is clear.
// Ports    : vi_i        - per-slot alive flags
//            free_idx_o  - lowest free slot index (0 when none free)
//            any_free_o  - at least one slot is free
// Revision : 1.0 - initial release
// ============================================================================
module enemy_free_slot_finder
    import enemy_pkg::*;
(
    input  logic [N_SLOTS-1:0] vi_i,
    output logic [IDX_W-1:0]   free_idx_o,
    output logic               any_free_o
);

    // Scan from the top down so the last hit is the lowest free index.
    always_comb begin
        free_idx_o = '0;
        any_free_o = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!vi_i[i]) begin
                free_idx_o = IDX_W'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/enemy_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : enemy_slot_scheduler
// Purpose  : Owns the enemy slots feeding the pixel generator. Accepts spawns
//            over valid/ready, applies kills, and once per frame walks every
//            slot (one per cycle) advancing enemies and retiring those that
//            reach the bottom of the playfield.
// Ports    : clk_25MHz, rst_n         - clock, async active-low reset
//            frame_tick               - per-frame start pulse
//            spawn_valid/ready/type/x - spawn handshake and payload
//            hit_valid/hit_idx        - kill request
//            enemy_x/y/vi/type        - packed per-slot state buses
//            active_count             - number of alive slots
//            busy                     - frame update in progress
//            overrun                  - frame_tick seen while busy (pulse)
//            spawn_err                - spawn consumed with bad type (pulse)
// Revision : 1.0 - initial release
// ============================================================================
module enemy_slot_scheduler
    import enemy_pkg::*;
(
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        spawn_valid,
    output logic        spawn_ready,
    input  logic [2:0]  spawn_type,
    input  logic [8:0]  spawn_x,
    input  logic        hit_valid,
    input  logic [3:0]  hit_idx,
    output logic [89:0] enemy_x,
    output logic [89:0] enemy_y,
    output logic [9:0]  enemy_vi,
    output logic [29:0] enemy_type,
    output logic [3:0]  active_count,
    output logic        busy,
    output logic        overrun,
    output logic        spawn_err
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [COORD_W-1:0]   x_q    [N_SLOTS];
    logic [COORD_W-1:0]   x_d    [N_SLOTS];
    logic [COORD_W-1:0]   y_q    [N_SLOTS];
    logic [COORD_W-1:0]   y_d    [N_SLOTS];
    logic [TYPE_W-1:0]    type_q [N_SLOTS];
    logic [TYPE_W-1:0]    type_d [N_SLOTS];
    logic [N_SLOTS-1:0]   vi_q, vi_d;
    logic [IDX_W-1:0]     count_q, count_d;
    logic                 busy_q, overrun_q, overrun_d, spawn_err_q, spawn_err_d;
    logic [COORD_W:0]     ny_w;
    logic [IDX_W-1:0]     free_idx_w;
    logic                 any_free_w;
    logic                 spawn_fire_w;

    // Search runs on the registered flags, so a slot killed this cycle is
    // not handed to a spawn in the same cycle.
    enemy_free_slot_finder u_finder (
        .vi_i       (vi_q),
        .free_idx_o (free_idx_w),
        .any_free_o (any_free_w)
    );

    assign spawn_ready  = (state_q == ST_IDLE) && any_free_w && !frame_tick;
    assign spawn_fire_w = spawn_valid && spawn_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        x_d         = x_q;
        y_d         = y_q;
        type_d      = type_q;
        vi_d        = vi_q;
        overrun_d   = 1'b0;
        spawn_err_d = 1'b0;
        ny_w        = '0;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_UPDATE;
                    ptr_d   = '0;
                end
            end
            ST_UPDATE: begin
                overrun_d = frame_tick;
                if (vi_q[ptr_q]) begin
                    ny_w = {1'b0, y_q[ptr_q]} + enemy_speed(type_q[ptr_q]);
                    if (ny_w >= (COORD_W+1)'(Y_LIMIT)) begin
                        vi_d[ptr_q] = 1'b0;
                    end else begin
                        y_d[ptr_q] = ny_w[COORD_W-1:0];
                    end
                end
                if (ptr_q == LAST_SLOT) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase

        // Applied after the update so a kill overrides a same-cycle advance.
        if (hit_valid && (hit_idx < SLOT_LIMIT)) begin
            vi_d[hit_idx] = 1'b0;
        end

        // Spawns only happen in IDLE, so they never collide with an update.
        if (spawn_fire_w) begin
            if (spawn_type > ENEMY_T2) begin
                spawn_err_d = 1'b1;
            end else begin
                x_d[free_idx_w]    = spawn_x;
                y_d[free_idx_w]    = '0;
                type_d[free_idx_w] = spawn_type;
                vi_d[free_idx_w]   = 1'b1;
            end
        end

        count_d = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            count_d = count_d + IDX_W'(vi_d[i]);
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            x_q         <= '{default: '0};
            y_q         <= '{default: '0};
            type_q      <= '{default: '0};
            vi_q        <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            spawn_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            type_q      <= type_d;
            vi_q        <= vi_d;
            count_q     <= count_d;
            busy_q      <= (state_d == ST_UPDATE);
            overrun_q   <= overrun_d;
            spawn_err_q <= spawn_err_d;
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
        assign enemy_x[COORD_W*g +: COORD_W]  = x_q[g];
        assign enemy_y[COORD_W*g +: COORD_W]  = y_q[g];
        assign enemy_type[TYPE_W*g +: TYPE_W] = type_q[g];
    end

    assign enemy_vi     = vi_q;
    assign active_count = count_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign spawn_err    = spawn_err_q;

endmodule
`default_nettype wire
